// File: rtl/cu_pkg.sv
// ----------------------------------------------------------------------------
// cu_pkg
// Shared definitions for the accumulator-datapath control unit: opcode
// constants, FSM state encoding, bus source codes and ALU operation codes.
// ----------------------------------------------------------------------------
package cu_pkg;

  localparam int OPW_DEF = 6;

  localparam logic [5:0] OP_NOP   = 6'h00;
  localparam logic [5:0] OP_LOAD  = 6'h01;
  localparam logic [5:0] OP_STORE = 6'h02;
  localparam logic [5:0] OP_ADD   = 6'h03;
  localparam logic [5:0] OP_SUB   = 6'h04;
  localparam logic [5:0] OP_JUMP  = 6'h05;
  localparam logic [5:0] OP_JMPZ  = 6'h06;
  localparam logic [5:0] OP_INCAC = 6'h07;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH1,
    S_FETCH2,
    S_FETCH3,
    S_DECODE,
    S_EXEC1,
    S_EXEC2,
    S_EXEC3,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_PC   = 3'd1,
    BUS_IR   = 3'd2,
    BUS_MEM  = 3'd3,
    BUS_AC   = 3'd4,
    BUS_ALU  = 3'd5
  } bus_sel_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_INC  = 3'd3
  } alu_op_t;

endpackage

// File: rtl/cu_op_decode.sv
// ----------------------------------------------------------------------------
// cu_op_decode
// Combinational opcode classifier used by the control FSM in DECODE.
//   opcode     in   OPW  opcode from the instruction register
//   exec_len   out  2    number of EXEC states the opcode needs (1..3)
//   is_illegal out  1    opcode is not a defined instruction
//   is_halt    out  1    opcode is HALT (no EXEC states)
// ----------------------------------------------------------------------------
module cu_op_decode
  import cu_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic [OPW-1:0] opcode,
  output logic [1:0]     exec_len,
  output logic           is_illegal,
  output logic           is_halt
);

  // NOTE: every output gets a default before the case so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    exec_len   = 2'd1;
    is_illegal = 1'b0;
    is_halt    = 1'b0;
    case (opcode)
      OPW'(OP_LOAD), OPW'(OP_ADD), OPW'(OP_SUB): exec_len = 2'd3;
      OPW'(OP_STORE):                            exec_len = 2'd2;
      OPW'(OP_NOP), OPW'(OP_JUMP), OPW'(OP_JMPZ), OPW'(OP_INCAC): exec_len = 2'd1;
      OPW'(OP_HALT):                             is_halt = 1'b1;
      // Unknown opcodes run a single do-nothing EXEC cycle, like NOP.
      default:                                   is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
// Multi-cycle fetch/decode/execute sequencer for the accumulator datapath.
//   clk, rst        clock, asynchronous active-high reset
//   start           leave IDLE and begin fetching
//   instruction     opcode from the instruction register (valid in DECODE)
//   z_flag          accumulator-zero flag (used by JMPZ in EXEC1)
//   ar_write, pc_write, pc_inc, ir_write, ac_write   register strobes
//   mem_read, mem_write                               memory strobes (addr=AR)
//   bus_sel         bus source: 0 none,1 PC,2 IR addr,3 MEM,4 AC,5 ALU
//   alu_op          0 PASS,1 ADD,2 SUB,3 INC
//   halted          high while parked in HALT
//   illegal         one-cycle pulse in EXEC1 of an unknown opcode
//   retired         instructions completed since reset (wraps)
// Outputs are decoded from the state register and the registered opcode, so
// they fall to zero as soon as reset asynchronously clears the state.
// ----------------------------------------------------------------------------
module control_unit
  import cu_pkg::*;
#(
  parameter int OPW   = OPW_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   instruction,
  input  logic             z_flag,
  output logic             ar_write,
  output logic             pc_write,
  output logic             pc_inc,
  output logic             ir_write,
  output logic             ac_write,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       bus_sel,
  output logic [2:0]       alu_op,
  output logic             halted,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t         state;
  logic [OPW-1:0] op;
  logic [1:0]     exec_len_q;
  logic           illegal_q;

  logic [1:0]     dec_len;
  logic           dec_illegal;
  logic           dec_halt;
  logic           last_exec;

  cu_op_decode #(.OPW(OPW)) u_op_decode (
    .opcode     (instruction),
    .exec_len   (dec_len),
    .is_illegal (dec_illegal),
    .is_halt    (dec_halt)
  );

  always_comb begin
    last_exec = (state == S_EXEC3) ||
                (state == S_EXEC1 && exec_len_q == 2'd1) ||
                (state == S_EXEC2 && exec_len_q == 2'd2);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      op         <= '0;
      exec_len_q <= 2'd0;
      illegal_q  <= 1'b0;
      retired    <= '0;
    end else begin
      // HALT counts as retired on entry, so DECODE->HALT also increments.
      if (last_exec || (state == S_DECODE && dec_halt))
        retired <= retired + CNT_W'(1);

      case (state)
        S_IDLE:   if (start) state <= S_FETCH1;
        S_FETCH1: state <= S_FETCH2;
        S_FETCH2: state <= S_FETCH3;
        S_FETCH3: state <= S_DECODE;
        S_DECODE: begin
          op         <= instruction;
          exec_len_q <= dec_len;
          illegal_q  <= dec_illegal;
          state      <= dec_halt ? S_HALT : S_EXEC1;
        end
        S_EXEC1:  state <= (exec_len_q == 2'd1) ? S_FETCH1 : S_EXEC2;
        S_EXEC2:  state <= (exec_len_q == 2'd2) ? S_FETCH1 : S_EXEC3;
        S_EXEC3:  state <= S_FETCH1;
        S_HALT:   state <= S_HALT;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ar_write  = 1'b0;
    pc_write  = 1'b0;
    pc_inc    = 1'b0;
    ir_write  = 1'b0;
    ac_write  = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    bus_sel   = BUS_NONE;
    alu_op    = ALU_PASS;
    halted    = (state == S_HALT);
    illegal   = (state == S_EXEC1) && illegal_q;

    case (state)
      S_FETCH1: begin bus_sel = BUS_PC; ar_write = 1'b1; end
      S_FETCH2: mem_read = 1'b1;
      S_FETCH3: begin bus_sel = BUS_MEM; ir_write = 1'b1; pc_inc = 1'b1; end
      S_EXEC1: begin
        case (op)
          OPW'(OP_LOAD), OPW'(OP_STORE), OPW'(OP_ADD), OPW'(OP_SUB): begin
            bus_sel  = BUS_IR;
            ar_write = 1'b1;
          end
          OPW'(OP_JUMP): begin bus_sel = BUS_IR; pc_write = 1'b1; end
          // JMPZ is the only output that looks at a live input.
          OPW'(OP_JMPZ): if (z_flag) begin bus_sel = BUS_IR; pc_write = 1'b1; end
          OPW'(OP_INCAC): begin alu_op = ALU_INC; bus_sel = BUS_ALU; ac_write = 1'b1; end
          default: ;
        endcase
      end
      S_EXEC2: begin
        case (op)
          OPW'(OP_LOAD), OPW'(OP_ADD), OPW'(OP_SUB): mem_read = 1'b1;
          OPW'(OP_STORE): begin bus_sel = BUS_AC; mem_write = 1'b1; end
          default: ;
        endcase
      end
      S_EXEC3: begin
        case (op)
          OPW'(OP_LOAD): begin bus_sel = BUS_MEM; ac_write = 1'b1; end
          OPW'(OP_ADD):  begin alu_op = ALU_ADD; bus_sel = BUS_ALU; ac_write = 1'b1; end
          OPW'(OP_SUB):  begin alu_op = ALU_SUB; bus_sel = BUS_ALU; ac_write = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// ----------------------------------------------------------------------------
// tb_control_unit
// Scoreboard bench for control_unit. The stimulus process drives one cycle at
// a time and queues the hand-derived output vector expected for that cycle;
// an independent monitor pops and compares on each falling edge. A narrow
// retired counter makes the wrap from all-ones to zero reachable quickly.
// ----------------------------------------------------------------------------
module tb_control_unit;

  localparam int OPW   = 6;
  localparam int CNT_W = 4;

  // Strobe bit positions: ar, pc, pc_inc, ir, ac, mem_read, mem_write
  localparam logic [6:0] S_AR  = 7'b1000000;
  localparam logic [6:0] S_PC  = 7'b0100000;
  localparam logic [6:0] S_PCI = 7'b0010000;
  localparam logic [6:0] S_IR  = 7'b0001000;
  localparam logic [6:0] S_AC  = 7'b0000100;
  localparam logic [6:0] S_MR  = 7'b0000010;
  localparam logic [6:0] S_MW  = 7'b0000001;

  typedef struct packed {
    logic [6:0]       strb;
    logic [2:0]       bus;
    logic [2:0]       alu;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [OPW-1:0]   instruction;
  logic             z_flag;
  logic             ar_write, pc_write, pc_inc, ir_write, ac_write;
  logic             mem_read, mem_write;
  logic [2:0]       bus_sel, alu_op;
  logic             halted, illegal;
  logic [CNT_W-1:0] retired;

  control_unit #(.OPW(OPW), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .instruction (instruction),
    .z_flag      (z_flag),
    .ar_write    (ar_write),
    .pc_write    (pc_write),
    .pc_inc      (pc_inc),
    .ir_write    (ir_write),
    .ac_write    (ac_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .bus_sel     (bus_sel),
    .alu_op      (alu_op),
    .halted      (halted),
    .illegal     (illegal),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  int               errors = 0;
  int               checks = 0;
  obs_t             exp_q[$];
  string            name_q[$];
  logic [CNT_W-1:0] exp_ret = '0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic obs_t observed();
    return {ar_write, pc_write, pc_inc, ir_write, ac_write, mem_read, mem_write,
            bus_sel, alu_op, halted, illegal, retired};
  endfunction

  function automatic obs_t mk(input logic [6:0] s, input logic [2:0] b, input logic [2:0] a);
    obs_t e;
    e.strb    = s;
    e.bus     = b;
    e.alu     = a;
    e.halted  = 1'b0;
    e.illegal = 1'b0;
    e.retired = exp_ret;
    return e;
  endfunction

  // Queue the expectation for the current cycle, then advance one cycle.
  task automatic cyc(input string nm, input obs_t e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [OPW-1:0] opc, input logic z);
    instruction = opc;
    z_flag      = z;
    cyc("fetch1", mk(S_AR, 3'd1, 3'd0));
    cyc("fetch2", mk(S_MR, 3'd0, 3'd0));
    cyc("fetch3", mk(S_IR | S_PCI, 3'd3, 3'd0));
    cyc("decode", mk(7'd0, 3'd0, 3'd0));
  endtask

  task automatic run_instr(input logic [OPW-1:0] opc, input logic z);
    obs_t e;
    fetch_decode(opc, z);
    case (opc)
      6'h00: cyc("nop_e1", mk(7'd0, 3'd0, 3'd0));
      6'h01: begin
        cyc("load_e1", mk(S_AR, 3'd2, 3'd0));
        cyc("load_e2", mk(S_MR, 3'd0, 3'd0));
        cyc("load_e3", mk(S_AC, 3'd3, 3'd0));
      end
      6'h02: begin
        cyc("store_e1", mk(S_AR, 3'd2, 3'd0));
        cyc("store_e2", mk(S_MW, 3'd4, 3'd0));
      end
      6'h03: begin
        cyc("add_e1", mk(S_AR, 3'd2, 3'd0));
        cyc("add_e2", mk(S_MR, 3'd0, 3'd0));
        cyc("add_e3", mk(S_AC, 3'd5, 3'd1));
      end
      6'h04: begin
        cyc("sub_e1", mk(S_AR, 3'd2, 3'd0));
        cyc("sub_e2", mk(S_MR, 3'd0, 3'd0));
        cyc("sub_e3", mk(S_AC, 3'd5, 3'd2));
      end
      6'h05: cyc("jump_e1", mk(S_PC, 3'd2, 3'd0));
      6'h06: begin
        if (z) cyc("jmpz_taken_e1", mk(S_PC, 3'd2, 3'd0));
        else   cyc("jmpz_not_taken_e1", mk(7'd0, 3'd0, 3'd0));
      end
      6'h07: cyc("incac_e1", mk(S_AC, 3'd5, 3'd3));
      6'h3F: begin
        exp_ret++;
        e = mk(7'd0, 3'd0, 3'd0);
        e.halted = 1'b1;
        cyc("halt_entry", e);
        return;
      end
      default: begin
        e = mk(7'd0, 3'd0, 3'd0);
        e.illegal = 1'b1;
        cyc("illegal_e1", e);
      end
    endcase
    exp_ret++;
  endtask

  // Monitor: compares the DUT outputs against the scoreboard mid-cycle.
  initial begin
    obs_t  e;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, 32'(observed()), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

  initial begin
    obs_t e;
    rst = 1'b1; start = 1'b0; instruction = '0; z_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(observed()), 32'd0);
    rst = 1'b0;

    // IDLE without start stays quiet.
    cyc("idle", mk(7'd0, 3'd0, 3'd0));
    cyc("idle", mk(7'd0, 3'd0, 3'd0));
    start = 1'b1;
    cyc("idle_start", mk(7'd0, 3'd0, 3'd0));
    start = 1'b0;

    run_instr(6'h01, 1'b0);  // LOAD
    run_instr(6'h02, 1'b0);  // STORE
    run_instr(6'h03, 1'b0);  // ADD
    run_instr(6'h04, 1'b0);  // SUB
    run_instr(6'h06, 1'b0);  // JMPZ, not taken
    run_instr(6'h06, 1'b1);  // JMPZ, taken
    run_instr(6'h05, 1'b0);  // JUMP
    run_instr(6'h07, 1'b0);  // INCAC
    run_instr(6'h00, 1'b0);  // NOP
    run_instr(6'h2A, 1'b0);  // illegal
    run_instr(6'h3F, 1'b0);  // HALT

    // Parked in HALT: start is ignored.
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      e = mk(7'd0, 3'd0, 3'd0);
      e.halted = 1'b1;
      cyc("halt_parked", e);
    end
    start = 1'b0;
    rst = 1'b1;
    #1;
    check("halt_rst_outputs", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ret = '0;
    cyc("idle_after_halt_rst", mk(7'd0, 3'd0, 3'd0));

    // Reset in the middle of LOAD's EXEC2.
    start = 1'b1;
    cyc("idle_start", mk(7'd0, 3'd0, 3'd0));
    start = 1'b0;
    fetch_decode(6'h01, 1'b0);
    cyc("load_e1", mk(S_AR, 3'd2, 3'd0));
    check("load_e2_mem_read", 32'(mem_read), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_instr_rst_outputs", 32'(observed()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ret = '0;

    // Retire 2**CNT_W instructions so the counter passes all-ones and wraps.
    start = 1'b1;
    cyc("idle_start", mk(7'd0, 3'd0, 3'd0));
    start = 1'b0;
    for (int i = 0; i < (1 << CNT_W); i++)
      run_instr((i % 2 == 0) ? 6'h00 : 6'h07, 1'b0);
    cyc("wrap_fetch1", mk(S_AR, 3'd1, 3'd0));
    check("retired_wrapped", 32'(retired), 32'd0);

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
